// File: rtl/serial_sat_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial saturating adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_PADDSB = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [15:0] SAT16_POS = 16'h7FFF;
  localparam logic [15:0] SAT16_NEG = 16'h8000;
  localparam int          NIBBLES   = 4;

endpackage

// File: rtl/serial_sat_add_ctrl_if.sv
// Request/response bundle between the ALU stage and the serial adder controller.
interface serial_sat_add_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;

  modport master (
    output start, op, a, b,
    input  busy, done, result, flag_n, flag_z, flag_v
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, flag_n, flag_z, flag_v
  );
endinterface

// File: rtl/serial_sat_add_ctrl_cla4_slice.sv
// 4-bit carry-look-ahead slice; when sat is set a signed lane overflow clamps to 0x7/0x8.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  input  logic       sat,
  output logic [3:0] sum,
  output logic       c3,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] raw;

  assign g = x & y;
  assign p = x ^ y;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign raw  = p ^ c[3:0];
  assign c3   = c[3];
  assign cout = c[4];

  // Overflow only when both lane operands share a sign, so x[3] gives the clamp direction.
  assign sum = (sat && (c[3] ^ c[4])) ? (x[3] ? 4'h8 : 4'h7) : raw;
endmodule

// File: rtl/serial_sat_add_ctrl.sv
// Nibble-serial saturating ADD/SUB/PADDSB controller; SERIAL_SUB_EN enables op 01 as SUB.
module serial_sat_add_ctrl
  import serial_add_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  serial_sat_add_ctrl_if.slave  bus
);
  localparam logic [1:0] LAST_NIB = 2'(NIBBLES - 1);

  state_e      state, state_nx;
  op_e         op_q, op_dec;
  logic [1:0]  cnt;
  logic [15:0] opa, opb, part, b_in;
  logic        carry_q;
  logic [15:0] result_q;
  logic        n_q, z_q, v_q;

  logic [3:0]  nib_a, nib_b, nib_sum;
  logic        nib_cin, nib_c3, nib_cout;
  logic        is_sub, is_packed, accept, last, ov16;
  logic [15:0] full, final_res;

  always_comb begin
    unique case (bus.op)
      2'b00:   op_dec = OP_ADD;
`ifdef SERIAL_SUB_EN
      2'b01:   op_dec = OP_SUB;
`else
      2'b01:   op_dec = OP_ADD;
`endif
      default: op_dec = OP_PADDSB;
    endcase
  end

`ifdef SERIAL_SUB_EN
  assign b_in   = (op_dec == OP_SUB) ? ~bus.b : bus.b;
  assign is_sub = (op_q == OP_SUB);
`else
  assign b_in   = bus.b;
  assign is_sub = 1'b0;
`endif

  assign is_packed = (op_q == OP_PADDSB);
  assign accept    = (state == ST_IDLE) && bus.start;
  assign last      = (state == ST_RUN) && (cnt == LAST_NIB);

  assign nib_a   = opa[{cnt, 2'b00} +: 4];
  assign nib_b   = opb[{cnt, 2'b00} +: 4];
  assign nib_cin = is_packed ? 1'b0 : ((cnt == 2'd0) ? is_sub : carry_q);

  cla4_slice u_slice (
    .x    (nib_a),
    .y    (nib_b),
    .cin  (nib_cin),
    .sat  (is_packed),
    .sum  (nib_sum),
    .c3   (nib_c3),
    .cout (nib_cout)
  );

  // Only meaningful on the last nibble, when the upper slice output completes the word.
  assign full      = {nib_sum, part[11:0]};
  assign ov16      = !is_packed && (nib_c3 ^ nib_cout);
  assign final_res = ov16 ? (opa[15] ? SAT16_NEG : SAT16_POS) : full;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nx = ST_RUN;
      ST_RUN:  if (cnt == LAST_NIB) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      ST_RUN:  bus.busy = 1'b1;
      ST_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: operand and partial-result registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa  <= bus.a;
      opb  <= b_in;
      op_q <= op_dec;
      part <= '0;
    end else if (state == ST_RUN) begin
      part[{cnt, 2'b00} +: 4] <= nib_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      carry_q  <= 1'b0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else if (accept) begin
      cnt     <= 2'd0;
      carry_q <= 1'b0;
    end else if (state == ST_RUN) begin
      carry_q <= nib_cout;
      if (last) begin
        result_q <= final_res;
        n_q      <= final_res[15];
        z_q      <= (final_res == 16'h0000);
        v_q      <= ov16;
      end else begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  assign bus.result = result_q;
  assign bus.flag_n = n_q;
  assign bus.flag_z = z_q;
  assign bus.flag_v = v_q;
endmodule

// File: tb/tb_serial_sat_add_ctrl.sv
// Directed bench for serial_sat_add_ctrl; SUB expectations follow SERIAL_SUB_EN.
module tb_serial_sat_add_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_sat_add_ctrl_if bus_if ();

  serial_sat_add_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in the current cycle n; returns in cycle n+6 with the controller idle.
  task automatic run_op(input string tag, input logic [1:0] opc, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_r, input logic exp_n,
                        input logic exp_z, input logic exp_v);
    bus_if.start = 1'b1;
    bus_if.op    = opc;
    bus_if.a     = a;
    bus_if.b     = b;
    step();
    bus_if.start = 1'b0;
    bus_if.a     = ~a;
    bus_if.b     = ~b;
    for (int k = 1; k <= 5; k++) begin
      check({tag, " busy"}, 16'(bus_if.busy), 16'd1);
      check({tag, " done"}, 16'(bus_if.done), (k == 5) ? 16'd1 : 16'd0);
      if (k < 5) step();
    end
    check({tag, " result"}, bus_if.result, exp_r);
    check({tag, " flag_n"}, 16'(bus_if.flag_n), 16'(exp_n));
    check({tag, " flag_z"}, 16'(bus_if.flag_z), 16'(exp_z));
    check({tag, " flag_v"}, 16'(bus_if.flag_v), 16'(exp_v));
    step();
    check({tag, " idle busy"}, 16'(bus_if.busy), 16'd0);
    check({tag, " idle done"}, 16'(bus_if.done), 16'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op    = 2'b00;
    bus_if.a     = '0;
    bus_if.b     = '0;
    step();
    step();
    check("rst busy",   16'(bus_if.busy),   16'd0);
    check("rst done",   16'(bus_if.done),   16'd0);
    check("rst result", bus_if.result,      16'h0000);
    check("rst flag_n", 16'(bus_if.flag_n), 16'd0);
    check("rst flag_z", 16'(bus_if.flag_z), 16'd0);
    check("rst flag_v", 16'(bus_if.flag_v), 16'd0);
    rst = 1'b0;

    run_op("add basic",    2'b00, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0);
    run_op("add sat pos",  2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    run_op("add zero",     2'b00, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("add sat neg",  2'b00, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_SUB_EN
    run_op("sub sat neg",  2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1);
    run_op("sub plain",    2'b01, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0, 1'b0);
`else
    run_op("op01 as add",  2'b01, 16'h8000, 16'h0001, 16'h8001, 1'b1, 1'b0, 1'b0);
`endif
    run_op("paddsb",       2'b10, 16'h7A81, 16'h1A8F, 16'h7880, 1'b0, 1'b0, 1'b0);
    run_op("op11 paddsb",  2'b11, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0);

    // Extra start pulses during RUN and DONE must be dropped, and operands not re-sampled.
    bus_if.start = 1'b1;
    bus_if.op    = 2'b00;
    bus_if.a     = 16'h0F0F;
    bus_if.b     = 16'h0101;
    step();                                   // n+1
    bus_if.start = 1'b0;
    step();                                   // n+2
    bus_if.start = 1'b1;
    bus_if.a     = 16'hFFFF;
    bus_if.b     = 16'hFFFF;
    check("pulse n+2 busy", 16'(bus_if.busy), 16'd1);
    step();                                   // n+3
    bus_if.start = 1'b0;
    step();                                   // n+4
    check("pulse n+4 done", 16'(bus_if.done), 16'd0);
    step();                                   // n+5
    bus_if.start = 1'b1;
    check("pulse n+5 done",   16'(bus_if.done), 16'd1);
    check("pulse n+5 result", bus_if.result,    16'h1010);
    step();                                   // n+6
    bus_if.start = 1'b0;
    check("pulse n+6 busy", 16'(bus_if.busy), 16'd0);
    check("pulse n+6 done", 16'(bus_if.done), 16'd0);
    step();                                   // n+7
    check("pulse n+7 busy", 16'(bus_if.busy), 16'd0);

    run_op("add after pulses", 2'b00, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0);

    // Reset in n+3 of an ADD, with a simultaneous start that must lose.
    bus_if.start = 1'b1;
    bus_if.op    = 2'b00;
    bus_if.a     = 16'h4000;
    bus_if.b     = 16'h0001;
    step();                                   // n+1
    bus_if.start = 1'b0;
    step();                                   // n+2
    step();                                   // n+3
    rst          = 1'b1;
    bus_if.start = 1'b1;
    step();                                   // n+4
    rst          = 1'b0;
    bus_if.start = 1'b0;
    check("abort n+4 busy",   16'(bus_if.busy),   16'd0);
    check("abort n+4 done",   16'(bus_if.done),   16'd0);
    check("abort n+4 result", bus_if.result,      16'h0000);
    check("abort n+4 flag_z", 16'(bus_if.flag_z), 16'd0);
    step();                                   // n+5
    check("abort n+5 done", 16'(bus_if.done), 16'd0);
    check("abort n+5 busy", 16'(bus_if.busy), 16'd0);

    run_op("add after abort", 2'b00, 16'hFFF0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_sat_add_ctrl.md
# serial_sat_add_ctrl

Multi-cycle controller that runs 16-bit saturating ADD/SUB and 4-lane saturating nibble add (PADDSB) through one shared 4-bit carry-look-ahead slice. It processes one nibble per cycle, chains carries between nibbles, and applies 16-bit or per-lane signed saturation. It returns the result with N/Z/V flags. It sits in the ALU stage as the area-reduced alternative to a full-width 16-bit adder.

## Interface
Parameters:
- none; width fixed at 16 bits, 4 nibbles.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `op`  in  2  00 ADD, 01 SUB, 10 PADDSB, 11 treated as PADDSB.
- `a`  in  16  operand A; sampled on the accept edge.
- `b`  in  16  operand B; sampled on the accept edge.
- `busy`  out  1  high from the cycle after accept through the DONE cycle.
- `done`  out  1  one-cycle pulse; `result` and flags valid.
- `result`  out  16  final value; held until the next completion.
- `flag_n`  out  1  result[15].
- `flag_z`  out  1  result == 0.
- `flag_v`  out  1  16-bit signed overflow occurred (ADD/SUB only; 0 for PADDSB).

## Operation
- States: IDLE, RUN, DONE. Nibble counter `cnt` is 2 bits.
- **IDLE, start=1:**
  - Latch `a` into `opa`.
  - Latch `b`, or `~b` for SUB, into `opb`.
  - Latch `op`, clear the partial result, set `cnt`=0, go to RUN.
- **RUN, each cycle, nibble i=`cnt`:**
  - Slice inputs are `opa[4i+3:4i]` and `opb[4i+3:4i]`.
  - ADD/SUB: carry-in = registered carry from nibble i-1. Nibble 0 gets 0 for ADD and 1 for SUB. Slice saturation control = 0.
  - PADDSB: carry-in = 0. Saturation control = 1, so the slice returns 0x7 or 0x8 on lane overflow and the raw sum otherwise.
  - Register the slice sum into result nibble i and the slice carry-out into `carry_q`.
  - At `cnt`=3:
    - Compute `v` = slice C3 XOR Cout (ADD/SUB only).
    - If `v`, the full result becomes 0x8000 when opa[15]=1, else 0x7FFF.
    - Flags are computed on the final, post-saturation result. Go to DONE.
- **DONE:** `done`=1 for this cycle, then IDLE.
- `start` in RUN or DONE is ignored. It is not queued.
- Operands are never re-sampled mid-operation.

## Timing
- `start` high in cycle n (IDLE) → nibbles 0..3 in cycles n+1..n+4 → `done` high in cycle n+5 → IDLE in n+6.
- Latency is 5 cycles. Earliest next accept is cycle n+6, so throughput is one op per 6 cycles.
- `busy` is high in cycles n+1..n+5 and low in IDLE.
- `result` and flags update only on the edge entering DONE. They are stable in the DONE cycle and afterwards.
- **Reset values:** `busy`=0, `done`=0, `result`=0x0000, `flag_n`=0, `flag_z`=0, `flag_v`=0, state IDLE, `cnt`=0, `carry_q`=0.
- **`rst` asserted mid-RUN or in DONE:**
  - Aborts the operation; the next cycle is IDLE with the reset values.
  - No `done` pulse for the aborted op.
  - `rst` overrides a simultaneous `start`.
- `cnt` does not wrap past 3. The 3→DONE transition is the only exit from RUN.

## Configuration
- `SERIAL_SUB_EN` defined:
  - op 01 performs SUB (B inverted, carry-in 1 at nibble 0).
- `SERIAL_SUB_EN` not defined:
  - op 01 is decoded as ADD: no inversion, carry-in 0.
  - The inverter and carry-in mux are removed. All other behaviour is identical.

## Structure
- Package `serial_add_pkg`:
  - op encoding enum (ADD, SUB, PADDSB).
  - state enum (IDLE, RUN, DONE).
  - constants SAT16_POS=0x7FFF, SAT16_NEG=0x8000, NIBBLES=4.
- One sub-module, `cla4_slice`:
  - 4-bit generate/propagate look-ahead adder with optional per-nibble saturation.
  - Outputs sum[3:0], C3, Cout.
  - Purely combinational; instantiated once.
- The controller holds the FSM, counter, operand/result registers, carry register and final 16-bit saturation/flag logic.

## Test plan
- ADD a=0x1234, b=0x1111, start in cycle n → `done` in n+5 only, result=0x2345, N=0, Z=0, V=0; `busy` high n+1..n+5.
- ADD a=0x7FFF, b=0x0001 → result=0x7FFF, V=1, N=0. ADD a=0x0001, b=0xFFFF → result=0x0000, Z=1, V=0.
- SUB a=0x8000, b=0x0001 (`SERIAL_SUB_EN` defined) → result=0x8000, V=1, N=1. Same stimulus without the macro → result=0x8001, V=0.
- PADDSB a=0x7A81, b=0x1A8F → result=0x7880 (lane sums 7+1 sat 7, A+A sat 8, 8+8 sat 8, 1+F=0), V=0.
- `start` pulsed again in n+2 and n+5 → ignored; a single `done` in n+5; next op accepted only when `start` is high in n+6 or later.
- `rst` high in cycle n+3 of an ADD → from n+4: `busy`=0, `done`=0, result=0x0000; no `done` in n+5.
